// File: rtl/led_sandbox_pkg.sv
// Shared widths, command entry type and IR encodings for the debug link.
// Defaults match the 2-bit IR / 38-bit SR OCI debug slave.
package led_sandbox_sopc_debug_pkg;

  localparam int IR_W_DEF    = 2;
  localparam int SR_W_DEF    = 38;
  localparam int ACT_BIT_DEF = 34;
  localparam int SYNC_DEF    = 2;
  localparam int DEPTH_DEF   = 4;

  localparam int N_ACT = 2 ** IR_W_DEF;
  localparam int PTR_W = $clog2(DEPTH_DEF);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] data;
  } cmd_t;

  localparam logic [IR_W_DEF-1:0] IR_OCIMEM_A  = 2'd0;
  localparam logic [IR_W_DEF-1:0] IR_OCIMEM_B  = 2'd1;
  localparam logic [IR_W_DEF-1:0] IR_TRACECTRL = 2'd2;
  localparam logic [IR_W_DEF-1:0] IR_BREAK     = 2'd3;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/led_sandbox_sopc_debug_cmd_fifo.sv
// Show-ahead command FIFO: head entry visible on dout while not empty.
// Ports: push/pop requests, din/dout, level, full/empty flags.
module led_sandbox_sopc_debug_cmd_fifo
  import led_sandbox_sopc_debug_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              dout,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rd_en = pop & ~empty;
  // A push into a full queue still fits when the head leaves this cycle.
  assign wr_en = push & (~full | rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/led_sandbox_sopc_debug_cmd_sync.sv
// Sysclk half of the debug link: syncs JTAG update strobes, queues cmds,
// issues one-hot action pulses. Ports: JTAG in, ready/valid out, status.
module led_sandbox_sopc_debug_cmd_sync
  import led_sandbox_sopc_debug_pkg::*;
#(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [SR_W-1:0]               sr,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic                          cmd_ready,
  input  logic                          ovf_clr,
  output logic                          cmd_valid,
  output logic [IR_W-1:0]               cmd_ir,
  output logic [SR_W-1:0]               jdo,
  output logic                          ir_update,
  output logic [2**IR_W-1:0]            take_action,
  output logic [2**IR_W-1:0]            take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_sticky
);

  localparam int NA    = 2 ** IR_W;
  localparam int CMD_W = IR_W + SR_W;
  localparam int WU_W  = $clog2(SYNC_STAGES + 2);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES must be 2..4");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (ACT_BIT >= SR_W) begin : g_bad_act
      $error("ACT_BIT must index into SR_W");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_prev;
  logic                   uir_prev;
  logic [WU_W-1:0]        warm;
  logic                   armed;
  logic                   udr_rise;
  logic                   uir_rise;

  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   drop;
  logic [CMD_W-1:0]       head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_prev <= 1'b0;
      uir_prev <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_prev <= uir_sync[SYNC_STAGES-1];
    end
  end

  // Warm-up hides a strobe that was already high when reset let go:
  // the chain fills with ones while detection is still masked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm <= WU_W'(SYNC_STAGES + 1);
    end else if (warm != '0) begin
      warm <= warm - 1'b1;
    end
  end

  assign armed    = (warm == '0);
  assign udr_rise = armed & udr_sync[SYNC_STAGES-1] & ~udr_prev;
  assign uir_rise = armed & uir_sync[SYNC_STAGES-1] & ~uir_prev;

  assign cmd_valid = ~empty;
  assign pop       = cmd_valid & cmd_ready;
  assign drop      = udr_rise & full & ~pop;
  assign cmd_ir    = head[CMD_W-1:SR_W];
  assign jdo       = head[SR_W-1:0];

  led_sandbox_sopc_debug_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (udr_rise),
    .pop     (pop),
    .din     ({ir_in, sr}),
    .dout    (head),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  // Pulse is decoded from the head as it leaves, so it lines up with
  // the pop edge and lasts one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      unique case (1'b1)
        pop & jdo[ACT_BIT]:  take_action[cmd_ir]    <= 1'b1;
        pop & ~jdo[ACT_BIT]: take_no_action[cmd_ir] <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_update <= 1'b0;
    end else begin
      ir_update <= uir_rise;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  logic [NA-1:0] unused_na;
  assign unused_na = '0;

endmodule

// File: tb/tb_led_sandbox_sopc_debug_cmd_sync.sv
// Randomised + directed bench for the debug command synchroniser.
// Model: sampled-strobe history with fixed latency and a command queue.
module tb_led_sandbox_sopc_debug_cmd_sync;
  import led_sandbox_sopc_debug_pkg::*;

  localparam int S = SYNC_DEF;
  localparam int D = DEPTH_DEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_udr;
  logic        vs_uir;
  logic        cmd_ready;
  logic        ovf_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic        ir_update;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic [2:0]  fifo_level;
  logic        ovf_sticky;

  led_sandbox_sopc_debug_cmd_sync dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (ir_in),
    .sr             (sr),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .ir_update      (ir_update),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_level     (fifo_level),
    .ovf_sticky     (ovf_sticky)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: strobe samples taken at each edge since reset;
  // a strobe seen high S edges ago and low S+1 edges ago is a rise,
  // honoured only once S+1 edges of warm-up have elapsed.
  cmd_t      q[$];
  bit [7:0]  udr_h;
  bit [7:0]  uir_h;
  int        k;
  bit [3:0]  exp_ta;
  bit [3:0]  exp_tna;
  bit        exp_iru;
  bit        exp_ovf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      udr_h = '0;
      uir_h = '0;
      k = 0;
      exp_ta = '0;
      exp_tna = '0;
      exp_iru = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      bit   ur;
      bit   ir_r;
      bit   drp;
      cmd_t e;
      k++;
      udr_h = {udr_h[6:0], vs_udr};
      uir_h = {uir_h[6:0], vs_uir};
      ur   = udr_h[S] && !udr_h[S+1] && (k >= S + 2);
      ir_r = uir_h[S] && !uir_h[S+1] && (k >= S + 2);
      exp_ta = '0;
      exp_tna = '0;
      if (q.size() > 0 && cmd_ready) begin
        e = q.pop_front();
        if (e.data[ACT_BIT_DEF]) exp_ta[e.ir] = 1'b1;
        else exp_tna[e.ir] = 1'b1;
      end
      drp = 1'b0;
      if (ur) begin
        if (q.size() < D) q.push_back('{ir: ir_in, data: sr});
        else drp = 1'b1;
      end
      if (drp) exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
      exp_iru = ir_r;
    end
  end

  always @(negedge clk) begin
    chk("cmd_valid", 64'(cmd_valid), 64'(q.size() != 0));
    chk("fifo_level", 64'(fifo_level), 64'(q.size()));
    if (q.size() != 0) begin
      chk("cmd_ir", 64'(cmd_ir), 64'(q[0].ir));
      chk("jdo", 64'(jdo), 64'(q[0].data));
    end
    chk("take_action", 64'(take_action), 64'(exp_ta));
    chk("take_no_action", 64'(take_no_action), 64'(exp_tna));
    chk("ir_update", 64'(ir_update), 64'(exp_iru));
    chk("ovf_sticky", 64'(ovf_sticky), 64'(exp_ovf));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic udr_pulse(input logic [1:0] ir, input logic [37:0] d);
    ir_in = ir;
    sr = d;
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(5);
  endtask

  function automatic logic [37:0] rnd_sr();
    return 38'({$urandom(), $urandom()});
  endfunction

  logic [37:0] srs [5];
  logic [37:0] v;

  initial begin
    reset_n = 1'b0;
    ir_in = '0;
    sr = '0;
    vs_udr = 1'b1;
    vs_uir = 1'b0;
    cmd_ready = 1'b0;
    ovf_clr = 1'b0;

    // Strobe high across reset release: nothing may be queued.
    tick(5);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(ovf_sticky), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("warm_level", 64'(fifo_level), 64'd0);
      chk("warm_valid", 64'(cmd_valid), 64'd0);
    end
    vs_udr = 1'b0;
    tick(4);

    // Action pulse on ir 2.
    cmd_ready = 1'b1;
    v = rnd_sr();
    v[34] = 1'b1;
    ir_in = 2'd2;
    sr = v;
    vs_udr = 1'b1;
    tick(3);
    chk("t2_valid", 64'(cmd_valid), 64'd1);
    chk("t2_jdo", 64'(jdo), 64'(v));
    tick();
    chk("t2_ta", 64'(take_action), 64'b0100);
    chk("t2_tna", 64'(take_no_action), 64'd0);
    tick();
    chk("t2_ta_off", 64'(take_action), 64'd0);
    vs_udr = 1'b0;
    tick(4);

    // No-action pulse on ir 1.
    v = rnd_sr();
    v[34] = 1'b0;
    ir_in = 2'd1;
    sr = v;
    vs_udr = 1'b1;
    tick(4);
    chk("t3_tna", 64'(take_no_action), 64'b0010);
    chk("t3_ta", 64'(take_action), 64'd0);
    vs_udr = 1'b0;
    tick(4);

    // Overflow: five pushes into a four-deep queue.
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      srs[i] = rnd_sr();
      udr_pulse(2'(i), srs[i]);
    end
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_set", 64'(ovf_sticky), 64'd1);
    chk("ovf_head", 64'(jdo), 64'(srs[0]));
    cmd_ready = 1'b1;
    tick(6);
    cmd_ready = 1'b0;
    chk("drain_level", 64'(fifo_level), 64'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(ovf_sticky), 64'd0);

    // Full queue, push coincides with pop.
    for (int i = 0; i < 4; i++) udr_pulse(2'(i), rnd_sr());
    ir_in = 2'd3;
    sr = rnd_sr();
    vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    vs_udr = 1'b0;
    chk("fullpp_level", 64'(fifo_level), 64'd4);
    chk("fullpp_ovf", 64'(ovf_sticky), 64'd0);
    cmd_ready = 1'b1;
    tick(6);
    cmd_ready = 1'b0;

    // Simultaneous IR/DR update, then reset with entries queued.
    ir_in = 2'd3;
    sr = rnd_sr();
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    tick(3);
    chk("both_iru", 64'(ir_update), 64'd1);
    chk("both_level", 64'(fifo_level), 64'd1);
    chk("both_ir", 64'(cmd_ir), 64'd3);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick(5);
    udr_pulse(2'd0, rnd_sr());
    chk("pre_rst_level", 64'(fifo_level), 64'd2);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_level", 64'(fifo_level), 64'd0);
      chk("post_rst_ta", 64'(take_action | take_no_action), 64'd0);
    end

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        if (!vs_udr) sr = rnd_sr();
        vs_udr = ~vs_udr;
      end
      if ($urandom_range(0, 9) == 0) begin
        if (!vs_uir && !vs_udr) ir_in = 2'($urandom_range(0, 3));
        vs_uir = ~vs_uir;
      end
      cmd_ready = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 600) == 0) begin
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_sandbox_sopc_debug_cmd_sync.md
Name: led_sandbox_sopc_debug_cmd_sync

Overview:
- System-clock half of the CPU debug-slave link: carries JTAG-side updates (virtual-JTAG update-DR / update-IR strobes, IR and shift-register contents) safely into the clk domain.
- Queues the resulting commands in a small FIFO and issues registered per-instruction take_action / take_no_action pulses to the OCI logic.
- Parametrised successor of the fixed 2-bit-IR / 38-bit-SR sysclk decoder, which holds only one command.
- Adds: command buffering, overflow reporting, a ready/valid consumer handshake, and reset warm-up.

Parameters:
- IR_W, 2, JTAG instruction width; number of action channels N_ACT = 2**IR_W.
- SR_W, 38, shift-register / command data width (jdo width).
- ACT_BIT, 34, bit of the command data selecting take_action (1) or take_no_action (0).
- SYNC_STAGES, 2, flip-flop stages per strobe synchroniser; legal 2..4.
- FIFO_DEPTH, 4, command queue entries; power of two, 2..16.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ir_in  in  IR_W  JTAG instruction; quasi-static, stable from vs_uir rise until the next IR scan.
- sr  in  SR_W  JTAG shift register; stable from vs_udr rise until the next DR capture.
- vs_udr  in  1  update-DR level, asynchronous to clk.
- vs_uir  in  1  update-IR level, asynchronous to clk.
- cmd_ready  in  1  consumer accepts the head command.
- ovf_clr  in  1  clears ovf_sticky.
- cmd_valid  out  1  FIFO not empty.
- cmd_ir  out  IR_W  head entry instruction.
- jdo  out  SR_W  head entry data (show-ahead).
- ir_update  out  1  one-cycle pulse per synchronised vs_uir rise.
- take_action  out  N_ACT  registered one-hot action pulse.
- take_no_action  out  N_ACT  registered one-hot no-action pulse.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- ovf_sticky  out  1  a command was dropped.

Behaviour:
- Reset: all outputs 0; FIFO empty; synchronisers 0; warm-up counter loaded with SYNC_STAGES+1.
- Warm-up:
  - Edge detection is masked while the counter is nonzero; the counter decrements each clk.
  - A strobe already high at reset release therefore produces no push and no ir_update.
- Synchronisers and edge detection:
  - vs_udr and vs_uir each pass through a SYNC_STAGES chain.
  - A rise is sync_last & ~sync_prev.
  - Latency: from the first clk edge sampling the strobe high, the FIFO push (or ir_update) occurs at edge SYNC_STAGES+1. With the default, cmd_valid is visible after the 3rd edge.
- Push: on a udr rise, write {ir_in, sr}, sampled at that edge.
- Pop: when cmd_valid & cmd_ready.
- Full:
  - A push while full and not popping is dropped, and ovf_sticky is set.
  - A simultaneous push and pop while full is accepted; level is unchanged.
- Empty: cmd_ready is ignored; no pop; no action pulse.
- Actions:
  - On a pop, the edge after the pop sets take_action[cmd_ir] = jdo[ACT_BIT] and take_no_action[cmd_ir] = ~jdo[ACT_BIT], for exactly 1 cycle.
  - Never both vectors nonzero; never more than one bit set.
- ovf_sticky: set by a drop, cleared by ovf_clr. Set wins when both occur in the same cycle.
- Pointers: pointer width is log2(FIFO_DEPTH); pointers wrap modulo depth; level saturates at FIFO_DEPTH.
- Simultaneous udr and uir rises: both are processed in the same cycle; the push uses the current ir_in.
- Reset mid-operation: FIFO contents are discarded, pulses cancelled, ovf cleared, and warm-up restarts.

Decomposition:
- Package led_sandbox_sopc_debug_pkg:
  - derived widths N_ACT, PTR_W, LVL_W;
  - typedef of the command entry struct {ir, data};
  - default IR encodings (OCIMEM_A=0, OCIMEM_B=1, TRACECTRL=2, BREAK=3).
- Sub-module led_sandbox_sopc_debug_cmd_fifo: synchronous show-ahead FIFO with level and full/empty flags.
- Synchronisers, warm-up counter and action decode stay in the top level.

Test Plan:
- Reset held 5 cycles with vs_udr=1, then release → no push, cmd_valid=0, level=0 throughout warm-up and after.
- ir_in=2, sr bit34=1, vs_udr rises, cmd_ready=1 → cmd_valid after edge 3, jdo=sr; take_action=4'b0100 for 1 cycle on the following edge; take_no_action=0.
- ir_in=1, sr bit34=0, cmd_ready=1 → take_no_action=4'b0010 for 1 cycle.
- cmd_ready=0, 5 udr pulses spaced 8 cycles apart → level=4, ovf_sticky=1 after the 5th; the 4 entries drain in order 1..4; ovf_clr → 0.
- FIFO full, a push coincides with a pop → level stays 4, ovf_sticky stays 0.
- vs_uir and vs_udr rise together; reset asserted with 2 entries queued → ir_update 1 pulse coincident with the push; after reset, level=0 and no stray pulses.
